// File: rtl/cnn_mac_pipe_dsp_if.sv
// cnn_mac_pipe_dsp_if: operand/result bundle of the pipelined signed MAC.
//
// Signals
//   ce        clock enable; 0 freezes every register in the MAC
//   in_valid  current beat carries an operand pair
//   first     beat opens a new accumulation (qualified by in_valid)
//   last      beat closes the accumulation (qualified by in_valid)
//   din0      signed activation operand
//   din1      signed weight operand
//   out_valid dout holds a completed result
//   dout      signed result
//   overflow  sticky overflow flag belonging to the result on dout
//
// Modports
//   master    stream source / result sink (drives operands and ce)
//   slave     the MAC itself
interface cnn_mac_pipe_dsp_if #(
    parameter int unsigned DIN0_WIDTH = 10,
    parameter int unsigned DIN1_WIDTH = 14,
    parameter int unsigned DOUT_WIDTH = 25
);
    logic                         ce;
    logic                         in_valid;
    logic                         first;
    logic                         last;
    logic signed [DIN0_WIDTH-1:0] din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic                         out_valid;
    logic signed [DOUT_WIDTH-1:0] dout;
    logic                         overflow;

    modport master (
        output ce,
        output in_valid,
        output first,
        output last,
        output din0,
        output din1,
        input  out_valid,
        input  dout,
        input  overflow
    );

    modport slave (
        input  ce,
        input  in_valid,
        input  first,
        input  last,
        input  din0,
        input  din1,
        output out_valid,
        output dout,
        output overflow
    );
endinterface

// File: rtl/cnn_mac_pipe_dsp.sv
// cnn_mac_pipe_dsp: pipelined, parametrised signed multiply-accumulate.
//
// MUL_STAGES registered product stages feed one accumulate stage. The
// accumulate stage also registers the scaled, range-limited result into dout
// on the edge that consumes a valid 'last' beat, so a 'last' beat presented at
// the input shows up on out_valid MUL_STAGES+1 enabled edges later.
//
// Ports
//   ap_clk    clock, rising edge
//   ap_rst_n  asynchronous active-low reset
//   bus       cnn_mac_pipe_dsp_if.slave (ce, in_valid, first, last, din0,
//             din1 in; out_valid, dout, overflow out)
//
// Parameters
//   DIN0_WIDTH/DIN1_WIDTH  signed operand widths
//   ACC_WIDTH              accumulator width (>= DIN0_WIDTH+DIN1_WIDTH)
//   DOUT_WIDTH             output width (<= ACC_WIDTH)
//   MUL_STAGES             product pipeline registers, 1..3
//   OUT_SHIFT              arithmetic right shift before output
//   SATURATE               1 = clamp on overflow, 0 = two's-complement wrap
module cnn_mac_pipe_dsp #(
    parameter int unsigned DIN0_WIDTH = 10,
    parameter int unsigned DIN1_WIDTH = 14,
    parameter int unsigned ACC_WIDTH  = 25,
    parameter int unsigned DOUT_WIDTH = 25,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned OUT_SHIFT  = 0,
    parameter bit          SATURATE   = 1'b1
) (
    input logic               ap_clk,
    input logic               ap_rst_n,
    cnn_mac_pipe_dsp_if.slave bus
);

    localparam int unsigned PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
    localparam int unsigned SUM_WIDTH  = ACC_WIDTH + 1;
    localparam int unsigned LAST       = MUL_STAGES - 1;
    // Bits of the scaled value that must all equal the sign to fit DOUT_WIDTH.
    localparam int unsigned HI_WIDTH   = ACC_WIDTH - DOUT_WIDTH + 1;

    localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX  = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN  = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
    localparam logic signed [DOUT_WIDTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WIDTH - 1){1'b1}}};
    localparam logic signed [DOUT_WIDTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WIDTH - 1){1'b0}}};

    // Multiply pipeline with its sideband shift register.
    logic signed [PROD_WIDTH-1:0] prod_in;
    logic signed [PROD_WIDTH-1:0] prod_q [MUL_STAGES];
    logic [MUL_STAGES-1:0]        vld_q;
    logic [MUL_STAGES-1:0]        first_q;
    logic [MUL_STAGES-1:0]        last_q;

    // Accumulate stage.
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic                         flag_q;
    logic signed [SUM_WIDTH-1:0]  prod_ext;
    logic signed [SUM_WIDTH-1:0]  acc_ext;
    logic signed [SUM_WIDTH-1:0]  sum;
    logic                         sum_ovf;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic                         flag_next;

    // Output stage.
    logic signed [ACC_WIDTH-1:0]  scaled;
    logic [HI_WIDTH-1:0]          scaled_hi;
    logic                         scaled_ovf;
    logic signed [DOUT_WIDTH-1:0] dout_next;
    logic                         out_valid_q;
    logic signed [DOUT_WIDTH-1:0] dout_q;
    logic                         ovf_q;

    logic                         acc_en;
    logic                         result_en;

    // Operands are widened before the multiply so the product is full precision.
    assign prod_in = PROD_WIDTH'(bus.din0) * PROD_WIDTH'(bus.din1);

    assign acc_en    = vld_q[LAST];
    assign result_en = vld_q[LAST] & last_q[LAST];

    always_comb begin
        prod_ext = SUM_WIDTH'(prod_q[LAST]);
        acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
        sum      = first_q[LAST] ? prod_ext : acc_ext + prod_ext;

        // The extra sum bit disagrees with the accumulator sign bit only when the
        // true result left the ACC_WIDTH range; sum[ACC_WIDTH] is the true sign.
        sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        if (sum_ovf && SATURATE) begin
            acc_next = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = sum[ACC_WIDTH-1:0];
        end

        // A 'first' beat restarts the sticky flag before folding in its own overflow.
        flag_next = (first_q[LAST] ? 1'b0 : flag_q) | sum_ovf;

        scaled     = acc_next >>> OUT_SHIFT;
        scaled_hi  = scaled[ACC_WIDTH-1:DOUT_WIDTH-1];
        scaled_ovf = !((&scaled_hi) || !(|scaled_hi));
        if (scaled_ovf && SATURATE) begin
            dout_next = scaled[ACC_WIDTH-1] ? DOUT_MIN : DOUT_MAX;
        end else begin
            dout_next = scaled[DOUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < int'(MUL_STAGES); i++) begin
                prod_q[i] <= '0;
            end
            vld_q       <= '0;
            first_q     <= '0;
            last_q      <= '0;
            acc_q       <= '0;
            flag_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (bus.ce) begin
            prod_q[0]  <= prod_in;
            vld_q[0]   <= bus.in_valid;
            first_q[0] <= bus.first;
            last_q[0]  <= bus.last;
            for (int i = 1; i < int'(MUL_STAGES); i++) begin
                prod_q[i]  <= prod_q[i-1];
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
            end

            // Bubbles leave the partial sum and its flag untouched.
            if (acc_en) begin
                acc_q  <= acc_next;
                flag_q <= flag_next;
            end

            // dout/overflow hold between results; out_valid is a one-enabled-cycle pulse.
            out_valid_q <= result_en;
            if (result_en) begin
                dout_q <= dout_next;
                ovf_q  <= flag_next | scaled_ovf;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_cnn_mac_pipe_dsp.sv
// Bench for cnn_mac_pipe_dsp. Three instances see the same operand stream:
//   dut_a  defaults (SATURATE=1, OUT_SHIFT=0, DOUT_WIDTH=25)
//   dut_b  SATURATE=0
//   dut_c  OUT_SHIFT=4, DOUT_WIDTH=16, SATURATE=1
// A reference model evaluates each vector arithmetically at the moment its
// beats are presented and schedules the result MUL_STAGES+1 enabled edges on.
module tb_cnn_mac_pipe_dsp;

    localparam int NDUT   = 3;
    localparam int ACC_W  = 25;
    localparam int LAT    = 2;   // enabled edges after the sampling edge
    localparam int NSLOT  = 4;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;

    always #5 ap_clk = ~ap_clk;

    cnn_mac_pipe_dsp_if #(.DIN0_WIDTH(10), .DIN1_WIDTH(14), .DOUT_WIDTH(25)) if_a ();
    cnn_mac_pipe_dsp_if #(.DIN0_WIDTH(10), .DIN1_WIDTH(14), .DOUT_WIDTH(25)) if_b ();
    cnn_mac_pipe_dsp_if #(.DIN0_WIDTH(10), .DIN1_WIDTH(14), .DOUT_WIDTH(16)) if_c ();

    cnn_mac_pipe_dsp #(.SATURATE(1'b1)) dut_a (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (if_a)
    );

    cnn_mac_pipe_dsp #(.SATURATE(1'b0)) dut_b (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (if_b)
    );

    cnn_mac_pipe_dsp #(.DOUT_WIDTH(16), .OUT_SHIFT(4), .SATURATE(1'b1)) dut_c (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (if_c)
    );

    int cfg_shift [NDUT] = '{0, 0, 4};
    int cfg_dw    [NDUT] = '{25, 25, 16};
    bit cfg_sat   [NDUT] = '{1'b1, 1'b0, 1'b1};

    longint m_acc  [NDUT];
    bit     m_flag [NDUT];
    bit     slot_v [NSLOT];
    longint slot_d [NDUT][NSLOT];
    bit     slot_o [NDUT][NSLOT];
    bit     exp_ov;
    longint exp_d  [NDUT];
    bit     exp_o  [NDUT];
    int     edge_n;

    int checks;
    int errors;

    longint res_a[$], res_b[$], res_c[$];
    bit     ovf_a[$], ovf_b[$], ovf_c[$];

    function automatic longint wrap(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_acc[k]  = 0;
            m_flag[k] = 1'b0;
            exp_d[k]  = 0;
            exp_o[k]  = 1'b0;
        end
        for (int s = 0; s < NSLOT; s++) slot_v[s] = 1'b0;
        exp_ov = 1'b0;
    endtask

    // One valid beat: update every configuration's running sum and, on 'last',
    // schedule the finished result into slot s.
    task automatic model_beat(input bit f, input bit l, input longint a, input longint b,
                              input int s);
        longint p, sum, lim, sc;
        bit     o;
        p = a * b;
        for (int k = 0; k < NDUT; k++) begin
            lim = longint'(1) << (ACC_W - 1);
            if (f) begin
                sum       = p;
                m_flag[k] = 1'b0;
            end else begin
                sum = m_acc[k] + p;
            end
            if (sum >= lim || sum < -lim) begin
                m_flag[k] = 1'b1;
                if (cfg_sat[k]) sum = (sum < 0) ? -lim : lim - 1;
                else            sum = wrap(sum, ACC_W);
            end
            m_acc[k] = sum;
            if (l) begin
                sc  = sum >>> cfg_shift[k];
                o   = m_flag[k];
                lim = longint'(1) << (cfg_dw[k] - 1);
                if (sc >= lim || sc < -lim) begin
                    o = 1'b1;
                    if (cfg_sat[k]) sc = (sc < 0) ? -lim : lim - 1;
                    else            sc = wrap(sc, cfg_dw[k]);
                end
                slot_d[k][s] = sc;
                slot_o[k][s] = o;
            end
        end
        if (l) slot_v[s] = 1'b1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        if (if_a.out_valid === 1'b1) begin
            res_a.push_back(longint'(if_a.dout));
            ovf_a.push_back(if_a.overflow);
        end
        if (if_b.out_valid === 1'b1) begin
            res_b.push_back(longint'(if_b.dout));
            ovf_b.push_back(if_b.overflow);
        end
        if (if_c.out_valid === 1'b1) begin
            res_c.push_back(longint'(if_c.dout));
            ovf_c.push_back(if_c.overflow);
        end
        chk_bit($sformatf("%s@%0d a.out_valid", tag, edge_n), if_a.out_valid, exp_ov);
        chk_val($sformatf("%s@%0d a.dout", tag, edge_n), 64'(if_a.dout), exp_d[0]);
        chk_bit($sformatf("%s@%0d a.overflow", tag, edge_n), if_a.overflow, exp_o[0]);
        chk_bit($sformatf("%s@%0d b.out_valid", tag, edge_n), if_b.out_valid, exp_ov);
        chk_val($sformatf("%s@%0d b.dout", tag, edge_n), 64'(if_b.dout), exp_d[1]);
        chk_bit($sformatf("%s@%0d b.overflow", tag, edge_n), if_b.overflow, exp_o[1]);
        chk_bit($sformatf("%s@%0d c.out_valid", tag, edge_n), if_c.out_valid, exp_ov);
        chk_val($sformatf("%s@%0d c.dout", tag, edge_n), 64'(if_c.dout), exp_d[2]);
        chk_bit($sformatf("%s@%0d c.overflow", tag, edge_n), if_c.overflow, exp_o[2]);
    endtask

    task automatic drive(input bit c, input bit v, input bit f, input bit l,
                         input int a, input int b);
        if_a.ce = c; if_a.in_valid = v; if_a.first = f; if_a.last = l;
        if_a.din0 = 10'(a); if_a.din1 = 14'(b);
        if_b.ce = c; if_b.in_valid = v; if_b.first = f; if_b.last = l;
        if_b.din0 = 10'(a); if_b.din1 = 14'(b);
        if_c.ce = c; if_c.in_valid = v; if_c.first = f; if_c.last = l;
        if_c.din0 = 10'(a); if_c.din1 = 14'(b);
    endtask

    // Present one beat, clock it, then compare all outputs 1 time unit later.
    task automatic step(input string tag, input bit c, input bit v, input bit f,
                        input bit l, input int a, input int b);
        int e;
        drive(c, v, f, l, a, b);
        e = edge_n;
        if (c && v) model_beat(f, l, longint'(a), longint'(b), (e + LAT) % NSLOT);
        @(posedge ap_clk);
        if (c) begin
            edge_n++;
            exp_ov = slot_v[e % NSLOT];
            if (exp_ov) begin
                for (int k = 0; k < NDUT; k++) begin
                    exp_d[k] = slot_d[k][e % NSLOT];
                    exp_o[k] = slot_o[k][e % NSLOT];
                end
            end
            slot_v[e % NSLOT] = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without a clock.
    task automatic pulse_reset(input string tag);
        #1 ap_rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1 ap_rst_n = 1'b1;
    endtask

    task automatic clear_results();
        res_a.delete(); res_b.delete(); res_c.delete();
        ovf_a.delete(); ovf_b.delete(); ovf_c.delete();
    endtask

    initial begin
        bit c, v, f, l;
        int a, b;

        checks = 0;
        errors = 0;
        edge_n = 0;
        model_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Reset state.
        repeat (2) @(posedge ap_clk);
        #1;
        check_all("reset");
        #1 ap_rst_n = 1'b1;
        clear_results();

        // Single-term vector.
        step("t1", 1'b1, 1'b1, 1'b1, 1'b1, -512, -8192);
        idle("t1", 4);
        chk_val("t1 pulse_count", 64'(res_a.size()), 1);
        chk_val("t1 dout", (res_a.size() > 0) ? res_a[0] : -1, 4194304);
        chk_bit("t1 overflow", (ovf_a.size() > 0) ? ovf_a[0] : 1'b1, 1'b0);

        // Four-term dot product with a bubble, then an immediate one-term vector.
        clear_results();
        step("t2", 1'b1, 1'b1, 1'b1, 1'b0, 3, 100);
        step("t2", 1'b1, 1'b1, 1'b0, 1'b0, -2, 50);
        step("t2", 1'b1, 1'b0, 1'b1, 1'b1, 77, 77);
        step("t2", 1'b1, 1'b1, 1'b0, 1'b0, 10, -7);
        step("t2", 1'b1, 1'b1, 1'b0, 1'b1, 1, 1);
        step("t2", 1'b1, 1'b1, 1'b1, 1'b1, 5, 5);
        idle("t2", 4);
        chk_val("t2 pulse_count", 64'(res_a.size()), 2);
        chk_val("t2 dout0", (res_a.size() > 0) ? res_a[0] : -1, 131);
        chk_val("t2 dout1", (res_a.size() > 1) ? res_a[1] : -1, 25);

        // Accumulator overflow: saturate on dut_a, wrap on dut_b.
        clear_results();
        for (int i = 0; i < 5; i++) begin
            step("t3", 1'b1, 1'b1, (i == 0), (i == 4), -512, -8192);
        end
        idle("t3", 3);
        chk_val("t3 sat dout", (res_a.size() > 0) ? res_a[0] : -1, 16777215);
        chk_bit("t3 sat overflow", (ovf_a.size() > 0) ? ovf_a[0] : 1'b0, 1'b1);
        chk_val("t3 wrap dout", (res_b.size() > 0) ? res_b[0] : -1, -12582912);
        chk_bit("t3 wrap overflow", (ovf_b.size() > 0) ? ovf_b[0] : 1'b0, 1'b1);
        clear_results();
        step("t3clean", 1'b1, 1'b1, 1'b1, 1'b1, 2, 3);
        idle("t3clean", 3);
        chk_val("t3clean dout", (res_a.size() > 0) ? res_a[0] : -1, 6);
        chk_bit("t3clean overflow", (ovf_a.size() > 0) ? ovf_a[0] : 1'b1, 1'b0);

        // Output scaling on dut_c.
        clear_results();
        step("t4", 1'b1, 1'b1, 1'b1, 1'b1, 100, -50);
        step("t4", 1'b1, 1'b1, 1'b1, 1'b1, 511, 8191);
        idle("t4", 3);
        chk_val("t4 floor dout", (res_c.size() > 0) ? res_c[0] : -1, -313);
        chk_bit("t4 floor overflow", (ovf_c.size() > 0) ? ovf_c[0] : 1'b1, 1'b0);
        chk_val("t4 clamp dout", (res_c.size() > 1) ? res_c[1] : -1, 32767);
        chk_bit("t4 clamp overflow", (ovf_c.size() > 1) ? ovf_c[1] : 1'b0, 1'b1);

        // Clock-enable stalls mid-stream and while the result is presented.
        clear_results();
        step("t5", 1'b1, 1'b1, 1'b1, 1'b0, 3, 100);
        step("t5", 1'b1, 1'b1, 1'b0, 1'b0, -2, 50);
        step("t5", 1'b0, 1'b1, 1'b1, 1'b1, 99, 99);
        step("t5", 1'b0, 1'b1, 1'b0, 1'b1, -99, 99);
        step("t5", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        step("t5", 1'b1, 1'b1, 1'b0, 1'b0, 10, -7);
        step("t5", 1'b1, 1'b1, 1'b0, 1'b1, 1, 1);
        idle("t5", 2);
        step("t5", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step("t5", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        idle("t5", 3);
        chk_val("t5 stretch_len", 64'(res_a.size()), 3);
        chk_val("t5 dout", (res_a.size() > 0) ? res_a[0] : -1, 131);
        chk_val("t5 dout_held", (res_a.size() > 2) ? res_a[2] : -1, 131);

        // Asynchronous reset in the middle of a vector.
        clear_results();
        step("t6", 1'b1, 1'b1, 1'b1, 1'b0, 3, 100);
        step("t6", 1'b1, 1'b1, 1'b0, 1'b0, -2, 50);
        pulse_reset("t6 async_rst");
        chk_bit("t6 rst out_valid", if_a.out_valid, 1'b0);
        chk_val("t6 rst dout", 64'(if_a.dout), 0);
        step("t6", 1'b1, 1'b1, 1'b1, 1'b1, 7, -3);
        idle("t6", 4);
        chk_val("t6 pulse_count", 64'(res_a.size()), 1);
        chk_val("t6 dout", (res_a.size() > 0) ? res_a[0] : -1, -21);

        // Randomized stream against the model, including a reset mid-run.
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 5) == 0);
            l = ($urandom_range(0, 5) == 0);
            a = int'($urandom_range(0, 1023)) - 512;
            b = int'($urandom_range(0, 16383)) - 8192;
            step("rand", c, v, f, l, a, b);
            if (i == 200) pulse_reset("rand async_rst");
        end
        idle("flush", 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_mac_pipe_dsp.md
# cnn_mac_pipe_dsp

Pipelined, parametrised signed multiply-accumulate unit. It generalises the single-cycle combinational DSP48 multiplier into a registered multiply stage followed by an accumulator. It sits in the conv-layer datapath: the weight × activation stream goes in, one accumulated dot-product result per vector comes out. Operand widths, multiplier pipeline depth, output scaling and saturation are all configurable, and a clock-enable stall is supported.

## Interface
- DIN0_WIDTH, 10, signed width of operand din0 (activation)
- DIN1_WIDTH, 14, signed width of operand din1 (weight)
- ACC_WIDTH, 25, accumulator width; must be ≥ DIN0_WIDTH+DIN1_WIDTH
- DOUT_WIDTH, 25, output width; must be ≤ ACC_WIDTH
- MUL_STAGES, 2, product pipeline registers, 1..3
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output, 0..ACC_WIDTH-1
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; 0 freezes every register
- in_valid  in  1  the current beat carries an operand pair
- first  in  1  the beat starts a new accumulation (qualified by in_valid)
- last  in  1  the beat ends the accumulation (qualified by in_valid)
- din0  in  DIN0_WIDTH  signed operand
- din1  in  DIN1_WIDTH  signed operand
- out_valid  out  1  dout holds a completed result
- dout  out  DOUT_WIDTH  signed result
- overflow  out  1  sticky overflow flag for the result currently on dout

## Operation
- **Pipeline:** MUL_STAGES product registers feed one accumulate stage. in_valid, first and last travel alongside the data in a shift register.
- **Product:** full-precision signed product, DIN0_WIDTH+DIN1_WIDTH bits, sign-extended to ACC_WIDTH+1 for the sum.
- **Accumulate stage, valid beat with first=1:** acc ← product. The internal overflow flag is cleared and then set if this beat overflows.
- **Accumulate stage, valid beat with first=0:** acc ← acc + product.
  - Overflow is detected on the (ACC_WIDTH+1)-bit sum.
  - SATURATE=1: clamp to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - SATURATE=0: wrap.
  - The internal flag is set on overflow either way.
- **Invalid beats (bubbles):** acc and flags are unchanged.
- **Valid beat with last=1 at the accumulate stage:**
  - On the same edge, register scaled = next_acc >>> OUT_SHIFT into dout.
  - If scaled does not fit DOUT_WIDTH, clamp it (SATURATE=1) or truncate it (SATURATE=0), and set overflow.
  - overflow = accumulated flag OR output-stage overflow.
  - Set out_valid=1.
- **Any other ce=1 edge:** out_valid ← 0. dout and overflow hold their last value.
- **first=1 and last=1 on the same beat:** the result is the single product.
- **first=1 with no preceding last:** the open partial sum is discarded silently; no output is produced.
- **Valid beat with first=0 before any first since reset:** accumulates onto acc (reset value 0).
- **ce=0:** all registers hold, including out_valid, so a pulse is stretched for the duration of the stall.

## Timing
- **Reset values:** out_valid=0, dout=0, overflow=0, acc=0, and all pipeline valid bits 0. Reset is immediate on ap_rst_n falling.
- **Reset mid-operation:** in-flight beats and the partial sum are discarded. The first valid beat after release is treated normally.
- **Latency:** MUL_STAGES+1 enabled cycles from a valid last beat at the input to out_valid=1. Default is 3 cycles.
- **Throughput:** one operand pair per enabled cycle, with no back-pressure.
- **Back-to-back vectors:** last on beat n and first on beat n+1 are both legal. This produces consecutive results, one out_valid pulse each, separated by the vector length.

## Test plan
1. **Single-term vector (defaults).** first=last=1, din0=-512, din1=-8192 → dout=4194304, overflow=0, out_valid high exactly 3 cycles later for 1 cycle.
2. **Four-term dot product.** Pairs (3,100), (-2,50), (10,-7), (1,1), the first beat flagged first and the fourth flagged last, with a bubble inserted after the 2nd beat → dout=131, and a second immediate vector (5,5) with first=last=1 → dout=25 on the next out_valid.
3. **Accumulator saturation.** Five beats of (-512,-8192), SATURATE=1 → dout=16777215, overflow=1. Repeat with SATURATE=0 → dout=20971520-33554432=-12582912, overflow=1. The next clean vector reports overflow=0.
4. **Output scaling.** OUT_SHIFT=4, DOUT_WIDTH=16, SATURATE=1:
   - single term (100,-50) → dout=-313 (arithmetic floor).
   - single term (511,8191) → dout=32767, overflow=1.
5. **CE stall.** Vector of test 2 with ce=0 for 2 cycles mid-stream and 2 cycles while out_valid=1 → same dout=131; out_valid is delayed by 2 and stretched to 3 cycles.
6. **Asynchronous reset mid-vector.** Pulse ap_rst_n low between clock edges after 2 beats → outputs are 0 immediately. A fresh vector (7,-3) with first=last=1 → dout=-21 and no stale result appears.
